// File: rtl/icache_direct_mapped_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;

  localparam int ADDR_W          = 10;
  localparam int NUM_BLOCKS      = 8;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 4;
  localparam int WSEL_W   = 2;
  localparam int BLOCK_W  = 128;
  localparam int BADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IC_IDLE     = 2'd0,
    IC_MEM_READ = 2'd1,
    IC_UPDATE   = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_direct_mapped_word_select.sv
// Picks one 32-bit word out of a 128-bit cache block; purely combinational.
module icache_direct_mapped_word_select
  import icache_direct_mapped_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [WSEL_W-1:0]  word_i,
  output logic [WORD_W-1:0]  word_o
);

  assign word_o = block_i[{word_i, 5'd0} +: WORD_W];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: zero-latency hits, one block fetch per miss.
// BUSYWAIT stalls the CPU from the missing cycle until the installed line hits.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  output logic [WORD_W-1:0]    INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic [BADDR_W-1:0]   MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]   MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
);

  ic_state_e state_q, state_d;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  logic [TAG_W-1:0]      fill_tag_q;
  logic [INDEX_W-1:0]    fill_idx_q;
  logic [BLOCK_W-1:0]    fill_data_q;

  logic [TAG_W-1:0]      pc_tag;
  logic [INDEX_W-1:0]    pc_idx;
  logic [WSEL_W-1:0]     pc_word;
  logic                  hit;
  logic [WORD_W-1:0]     sel_word;
  logic                  unused_pc_bits;

  assign pc_tag         = PC[ADDR_W-1 -: TAG_W];
  assign pc_idx         = PC[OFFSET_W +: INDEX_W];
  assign pc_word        = PC[OFFSET_W-1:2];
  assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

  assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  icache_direct_mapped_word_select u_word_select (
    .block_i (data_q[pc_idx]),
    .word_i  (pc_word),
    .word_o  (sel_word)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IC_IDLE:     if (!hit) state_d = IC_MEM_READ;
      IC_MEM_READ: if (!MEM_BUSYWAIT) state_d = IC_UPDATE;
      IC_UPDATE:   state_d = IC_IDLE;
      default:     state_d = IC_IDLE;
    endcase
  end

  // RESET gates the outputs directly so the CPU sees a defined stall signal from time zero.
  always_comb begin
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    BUSYWAIT    = 1'b1;
    case (state_q)
      IC_IDLE:     BUSYWAIT = !hit;
      IC_MEM_READ: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {fill_tag_q, fill_idx_q};
      end
      default:     BUSYWAIT = 1'b1;
    endcase
    if (RESET) begin
      MEM_READ    = 1'b0;
      MEM_ADDRESS = '0;
      BUSYWAIT    = 1'b0;
    end
    INSTRUCTION = (hit && !RESET) ? sel_word : '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q    <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
    end else begin
      if (state_q == IC_IDLE && !hit) begin
        fill_tag_q <= pc_tag;
        fill_idx_q <= pc_idx;
      end
      if (state_q == IC_UPDATE) valid_q[fill_idx_q] <= 1'b1;
    end
  end

  // Tag and data storage is never cleared; valid_q alone qualifies it.
  always_ff @(posedge CLK) begin
    if (state_q == IC_MEM_READ && !MEM_BUSYWAIT) fill_data_q <= MEM_READDATA;
    if (state_q == IC_UPDATE) begin
      tag_q[fill_idx_q]  <= fill_tag_q;
      data_q[fill_idx_q] <= fill_data_q;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped with a fixed-latency block memory model.
module tb_icache_direct_mapped;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 5;
  int cnt     = 0;

  icache_direct_mapped dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory: data valid in the lat-th cycle of a read request.
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [7:0] a8;
    a8 = {2'b00, a};
    if (a == 6'd0) return {32'h0D0C0B0A, 32'h09080706, 32'h05040302, 32'h01000000};
    return {a8, 8'd3, 16'hC0DE, a8, 8'd2, 16'hC0DE, a8, 8'd1, 16'hC0DE, a8, 8'd0, 16'hC0DE};
  endfunction

  always @(posedge CLK) begin
    if (!MEM_READ) cnt <= 0;
    else           cnt <= cnt + 1;
  end

  assign MEM_BUSYWAIT = MEM_READ && (cnt < lat - 1);
  assign MEM_READDATA = blk(MEM_ADDRESS);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Presents pc and waits for BUSYWAIT to drop, counting stall and request cycles.
  task automatic fetch(input logic [31:0] pc, output int busy, output int mrd,
                       output logic [5:0] maddr);
    busy  = 0;
    mrd   = 0;
    maddr = '0;
    PC = pc;
    #1;
    while (BUSYWAIT && busy < 60) begin
      busy++;
      if (MEM_READ) begin
        mrd++;
        maddr = MEM_ADDRESS;
      end
      step();
    end
    check("fetch_done", {31'd0, BUSYWAIT}, 32'd0);
  endtask

  int          busy, mrd;
  logic [5:0]  maddr;
  logic [31:0] seq_pc  [3];
  logic [31:0] seq_ins [3];

  initial begin
    seq_pc  = '{32'd4, 32'd8, 32'd12};
    seq_ins = '{32'h05040302, 32'h09080706, 32'h0D0C0B0A};

    RESET = 1'b1;
    PC    = 32'd0;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    check("rst_instr", INSTRUCTION, 32'd0);
    RESET = 1'b0;
    #1;
    check("post_rst_miss", {31'd0, BUSYWAIT}, 32'd1);

    // Cold miss, 5-cycle memory.
    fetch(32'd0, busy, mrd, maddr);
    check("cold_busy_cycles", busy, 32'd7);
    check("cold_mread_cycles", mrd, 32'd5);
    check("cold_mem_addr", {26'd0, maddr}, 32'd0);
    check("cold_instr", INSTRUCTION, 32'h01000000);

    for (int i = 0; i < 3; i++) begin
      step();
      PC = seq_pc[i];
      #1;
      check("seq_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("seq_instr", INSTRUCTION, seq_ins[i]);
      check("seq_mem_read", {31'd0, MEM_READ}, 32'd0);
    end

    // Conflict on index 0.
    step();
    fetch(32'd128, busy, mrd, maddr);
    check("conf_mem_addr", {26'd0, maddr}, 32'd8);
    check("conf_busy_cycles", busy, 32'd7);
    check("conf_instr", INSTRUCTION, 32'h0800C0DE);
    step();
    fetch(32'd0, busy, mrd, maddr);
    check("conf_back_busy", busy, 32'd7);
    check("conf_back_addr", {26'd0, maddr}, 32'd0);
    check("conf_back_instr", INSTRUCTION, 32'h01000000);

    // PC moves while block 1 is being fetched.
    step();
    PC = 32'd16;
    #1;
    check("mid_miss", {31'd0, BUSYWAIT}, 32'd1);
    step();
    check("mid_mread", {31'd0, MEM_READ}, 32'd1);
    check("mid_addr0", {26'd0, MEM_ADDRESS}, 32'd1);
    PC = 32'd32;
    step();
    check("mid_addr_held", {26'd0, MEM_ADDRESS}, 32'd1);
    fetch(32'd32, busy, mrd, maddr);
    check("mid_second_addr", {26'd0, maddr}, 32'd2);
    check("mid_pc32_instr", INSTRUCTION, 32'h0200C0DE);
    PC = 32'd36;
    #1;
    check("mid_pc36_instr", INSTRUCTION, 32'h0201C0DE);
    PC = 32'd16;
    #1;
    check("mid_line1_hit", {31'd0, BUSYWAIT}, 32'd0);
    check("mid_line1_instr", INSTRUCTION, 32'h0100C0DE);

    // Memory ready in the first request cycle.
    lat = 1;
    step();
    fetch(32'd48, busy, mrd, maddr);
    check("fast_busy_cycles", busy, 32'd3);
    check("fast_mread_cycles", mrd, 32'd1);
    check("fast_instr", INSTRUCTION, 32'h0300C0DE);

    // Reset while the memory is still busy.
    lat = 100;
    step();
    PC = 32'd64;
    step();
    step();
    check("rmid_mread", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("rmid_mread_drop", {31'd0, MEM_READ}, 32'd0);
    check("rmid_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("rmid_instr", INSTRUCTION, 32'd0);
    step();
    RESET = 1'b0;
    #1;
    check("rmid_still_miss", {31'd0, BUSYWAIT}, 32'd1);
    lat = 2;
    fetch(32'd64, busy, mrd, maddr);
    check("rmid_refetch_busy", busy, 32'd4);
    check("rmid_refetch_mread", mrd, 32'd2);
    check("rmid_refetch_addr", {26'd0, maddr}, 32'd4);
    check("rmid_refetch_instr", INSTRUCTION, 32'h0400C0DE);
    step();
    fetch(32'd8, busy, mrd, maddr);
    check("rmid_line0_cleared", busy, 32'd4);
    check("rmid_line0_instr", INSTRUCTION, 32'h09080706);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the 8-bit single-cycle CPU's PC output and the 128-bit-block instruction memory.
- Drives INSTRUCTION and BUSYWAIT. BUSYWAIT connects to the CPU's INSTRMEM_BUSYWAIT input, which holds PC and suppresses control while high.
- On a miss it fetches one 16-byte block from instruction memory via a read/busywait handshake, installs it, then serves the hit.

Parameters:
- ADDR_W, 10, byte-address bits of PC used. Bits above ADDR_W-1 are ignored.
- NUM_BLOCKS, 8, cache lines; index width = log2(NUM_BLOCKS) = 3.
- WORDS_PER_BLOCK, 4, 32-bit words per line; block = 128 bits, byte offset = 4 bits.

Ports:
- CLK  input  1  system clock, posedge active.
- RESET  input  1  asynchronous, active-high reset.
- PC  input  32  byte address from the CPU. PC[1:0] is ignored, so the address is word aligned.
- INSTRUCTION  output  32  fetched instruction word; valid when BUSYWAIT=0.
- BUSYWAIT  output  1  high while the requested word is not available.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  6  block address, equal to the latched PC[9:4].
- MEM_READDATA  input  128  returned block; word k is bits [32k+31:32k].
- MEM_BUSYWAIT  input  1  memory busy; data is valid in the cycle it falls low.

Behaviour:
- Address split: tag = PC[9:7], index = PC[6:4], word = PC[3:2].
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- Hit = valid[index] && tag match. Hit, word select and INSTRUCTION are combinational from PC; no cycle of latency on a hit.
- Reset, asynchronous, at any time including mid-fill:
  - all valid bits cleared; state goes to IDLE.
  - MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=0.
  - tag and data arrays are not cleared.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - BUSYWAIT = !hit while RESET is low.
  - On a miss at a posedge, latch tag and index, then go to MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS={latched tag, latched index}, BUSYWAIT=1.
  - Stay while MEM_BUSYWAIT=1.
  - At a posedge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
- UPDATE:
  - MEM_READ=0, BUSYWAIT=1.
  - At the next posedge write data and tag into the latched index, set valid, go to IDLE.
  - The CPU then sees a hit in the same cycle and BUSYWAIT falls combinationally.
- Miss penalty: memory latency + 2 cycles (UPDATE + return to IDLE).
- A PC change during a fill is ignored. The fill completes to the latched index/tag, then the current PC is re-evaluated in IDLE.
- Conflict miss (same index, different tag): the line is overwritten. No write-back, since the cache is read-only.
- MEM_BUSYWAIT already low in the first MEM_READ cycle: a single MEM_READ cycle is legal.
- BUSYWAIT must never be X after reset, so the CPU PC hold is well-defined from the first cycle.

Decomposition:
- Shared package holds:
  - state encoding constants IC_IDLE=2'd0, IC_MEM_READ=2'd1, IC_UPDATE=2'd2.
  - field widths TAG_W=3, INDEX_W=3, OFFSET_W=4.
  - BLOCK_W=128.
- One sub-module is natural: icache_word_select (128-bit block + 2-bit word index -> 32-bit word), purely combinational.
- The FSM and arrays stay in the top block.

Test Plan:
- Reset: assert RESET mid-cycle -> BUSYWAIT=0 and MEM_READ=0 immediately, all valid bits 0; the first fetch of PC=0 is a miss.
- Cold miss: PC=0, memory latency 5 cycles, block 0 = {32'h0D0C0B0A, 32'h09080706, 32'h05040302, 32'h01000000} -> MEM_READ=1 with MEM_ADDRESS=0 for 5 cycles, BUSYWAIT=1 for 7 cycles, then INSTRUCTION=32'h01000000 with BUSYWAIT=0.
- Sequential hits: PC=4, 8, 12 on consecutive cycles -> BUSYWAIT stays 0; INSTRUCTION = 32'h05040302, 32'h09080706, 32'h0D0C0B0A; MEM_READ stays 0.
- Conflict: PC=128 (index 0, tag 1) -> miss, MEM_ADDRESS=6'd8, line 0 replaced. Return to PC=0 -> miss again with MEM_ADDRESS=0.
- PC change mid-fill: miss on PC=16, PC driven to 32 during MEM_READ -> block 1 is installed. Then PC=32 misses with MEM_ADDRESS=2, and line 1 is valid afterwards.
- Reset during MEM_READ: RESET pulse while MEM_BUSYWAIT=1 -> MEM_READ drops immediately, the line stays invalid, and a re-fetch of the same PC misses again.
